// File: rtl/wb_master_arbiter.sv
// -----------------------------------------------------------------------------
// wb_master_arbiter
//
// Two-master, single-port Wishbone arbiter. Master 0 (RPi SPI bridge) and
// master 1 (on-chip DMA/capture engine) share the one master port of the bus
// interconnect.
//   * Round-robin between simultaneous requests; the grant is held for the
//     whole cyc and one IDLE turnaround cycle always separates two grants.
//   * While a master owns the bus its request is passed straight through and
//     the slave's ack/data come straight back (no added latency).
//   * A watchdog counts stb-without-ack cycles; on expiry the access is ended
//     with a one-cycle ABORT that acks the master with TIMEOUT_DATA and sets
//     the sticky timeout_o flag. Writes that time out are simply lost.
//
// Ports
//   clk, resetn            clock; synchronous reset, active high (1 = reset)
//   m0_* / m1_*            Wishbone slave-side ports for the two masters
//   s_*                    Wishbone master-side port to the interconnect
//   grant_o                one-hot owner {m1,m0}; 2'b00 when idle
//   timeout_o              sticky "an access timed out" flag
//   timeout_clr_i          clears timeout_o (a simultaneous timeout wins)
// -----------------------------------------------------------------------------
module wb_master_arbiter #(
    parameter int                    ADDR_WIDTH     = 15,
    parameter int                    DATA_WIDTH     = 16,
    parameter int                    TIMEOUT_CYCLES = 255,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA   = 16'hDEAD
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [DATA_WIDTH-1:0] m0_dat_i,
    output logic [DATA_WIDTH-1:0] m0_dat_o,
    input  logic [1:0]            m0_sel_i,
    input  logic                  m0_we_i,
    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    output logic                  m0_ack_o,
    input  logic [ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [DATA_WIDTH-1:0] m1_dat_i,
    output logic [DATA_WIDTH-1:0] m1_dat_o,
    input  logic [1:0]            m1_sel_i,
    input  logic                  m1_we_i,
    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    output logic                  m1_ack_o,
    output logic [ADDR_WIDTH-1:0] s_adr_o,
    output logic [DATA_WIDTH-1:0] s_dat_o,
    input  logic [DATA_WIDTH-1:0] s_dat_i,
    output logic [1:0]            s_sel_o,
    output logic                  s_we_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    input  logic                  s_ack_i,
    output logic [1:0]            grant_o,
    output logic                  timeout_o,
    input  logic                  timeout_clr_i
);

    localparam logic [1:0] STATE_IDLE  = 2'd0;
    localparam logic [1:0] STATE_OWN0  = 2'd1;
    localparam logic [1:0] STATE_OWN1  = 2'd2;
    localparam logic [1:0] STATE_ABORT = 2'd3;

    localparam int                  TIMER_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0]  TIMER_LIMIT = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]         state_q, state_d;
    logic               owner_q, owner_d;         // master currently granted
    logic               last_owner_q, last_owner_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               timeout_q, timeout_d;

    // Master ports gathered into arrays so the owner can be selected by index.
    logic [ADDR_WIDTH-1:0] m_adr [2];
    logic [DATA_WIDTH-1:0] m_dat [2];
    logic [1:0]            m_sel [2];
    logic [1:0]            m_we, m_cyc, m_stb, m_ack;
    logic [DATA_WIDTH-1:0] m_rdat [2];

    assign m_adr[0] = m0_adr_i;
    assign m_adr[1] = m1_adr_i;
    assign m_dat[0] = m0_dat_i;
    assign m_dat[1] = m1_dat_i;
    assign m_sel[0] = m0_sel_i;
    assign m_sel[1] = m1_sel_i;
    assign m_we     = {m1_we_i,  m0_we_i};
    assign m_cyc    = {m1_cyc_i, m0_cyc_i};
    assign m_stb    = {m1_stb_i, m0_stb_i};

    logic bus_active;
    logic aborting;
    assign bus_active = (state_q == STATE_OWN0) || (state_q == STATE_OWN1);
    assign aborting   = (state_q == STATE_ABORT);

    // Request path: pure pass-through from the owner, forced low otherwise.
    assign s_adr_o = bus_active ? m_adr[owner_q] : '0;
    assign s_dat_o = bus_active ? m_dat[owner_q] : '0;
    assign s_sel_o = bus_active ? m_sel[owner_q] : 2'b00;
    assign s_we_o  = bus_active & m_we[owner_q];
    assign s_cyc_o = bus_active & m_cyc[owner_q];
    assign s_stb_o = bus_active & m_stb[owner_q];

    assign grant_o   = (bus_active || aborting) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign timeout_o = timeout_q;

    // Response path per master. Acks are blocked while reset is asserted so a
    // transfer cut short by reset never completes.
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
        logic is_owner;
        assign is_owner   = (owner_q == 1'(gi));
        assign m_ack[gi]  = !resetn && is_owner &&
                            ((bus_active && s_ack_i) || aborting);
        assign m_rdat[gi] = !is_owner  ? '0 :
                            aborting   ? TIMEOUT_DATA :
                            bus_active ? s_dat_i : '0;
    end

    assign m0_ack_o = m_ack[0];
    assign m1_ack_o = m_ack[1];
    assign m0_dat_o = m_rdat[0];
    assign m1_dat_o = m_rdat[1];

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        timer_d      = timer_q;
        timeout_d    = timeout_q;

        if (timeout_clr_i) begin
            timeout_d = 1'b0;
        end

        case (state_q)
            STATE_IDLE: begin
                timer_d = '0;
                // On a tie the master that did not own the bus last wins.
                if (m_cyc[0] && (!m_cyc[1] || last_owner_q)) begin
                    state_d = STATE_OWN0;
                    owner_d = 1'b0;
                end else if (m_cyc[1]) begin
                    state_d = STATE_OWN1;
                    owner_d = 1'b1;
                end
            end
            STATE_OWN0, STATE_OWN1: begin
                if (!m_cyc[owner_q]) begin
                    state_d      = STATE_IDLE;
                    last_owner_d = owner_q;
                    timer_d      = '0;
                end else if (m_stb[owner_q] && !s_ack_i) begin
                    // An ack in the limit cycle takes the else branch below,
                    // so it completes normally instead of aborting.
                    if (timer_q == TIMER_LIMIT) begin
                        state_d = STATE_ABORT;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end else begin
                    timer_d = '0;
                end
            end
            STATE_ABORT: begin
                // Set after the clear above so a coincident clear loses.
                timeout_d = 1'b1;
                timer_d   = '0;
                if (m_cyc[owner_q]) begin
                    state_d = owner_q ? STATE_OWN1 : STATE_OWN0;
                end else begin
                    state_d      = STATE_IDLE;
                    last_owner_d = owner_q;
                end
            end
            default: begin
                state_d = STATE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q      <= STATE_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            timer_q      <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            timer_q      <= timer_d;
            timeout_q    <= timeout_d;
        end
    end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_master_arbiter
//
// Directed bench for wb_master_arbiter with TIMEOUT_CYCLES=8. Inputs change
// on the falling edge; outputs are sampled 1 time unit later, well away from
// the rising edge. Every comparison goes through check().
// -----------------------------------------------------------------------------
module tb_wb_master_arbiter;

    localparam int AW = 15;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          resetn;
    logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
    logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
    logic [1:0]    m0_sel_i, m1_sel_i, s_sel_o, grant_o;
    logic          m0_we_i, m0_cyc_i, m0_stb_i, m0_ack_o;
    logic          m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o;
    logic          s_we_o, s_cyc_o, s_stb_o, s_ack_i;
    logic          timeout_o, timeout_clr_i;

    int checks   = 0;
    int failures = 0;

    wb_master_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (8),
        .TIMEOUT_DATA   (16'hDEAD)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .m0_adr_i      (m0_adr_i),
        .m0_dat_i      (m0_dat_i),
        .m0_dat_o      (m0_dat_o),
        .m0_sel_i      (m0_sel_i),
        .m0_we_i       (m0_we_i),
        .m0_cyc_i      (m0_cyc_i),
        .m0_stb_i      (m0_stb_i),
        .m0_ack_o      (m0_ack_o),
        .m1_adr_i      (m1_adr_i),
        .m1_dat_i      (m1_dat_i),
        .m1_dat_o      (m1_dat_o),
        .m1_sel_i      (m1_sel_i),
        .m1_we_i       (m1_we_i),
        .m1_cyc_i      (m1_cyc_i),
        .m1_stb_i      (m1_stb_i),
        .m1_ack_o      (m1_ack_o),
        .s_adr_o       (s_adr_o),
        .s_dat_o       (s_dat_o),
        .s_dat_i       (s_dat_i),
        .s_sel_o       (s_sel_o),
        .s_we_o        (s_we_o),
        .s_cyc_o       (s_cyc_o),
        .s_stb_o       (s_stb_o),
        .s_ack_i       (s_ack_i),
        .grant_o       (grant_o),
        .timeout_o     (timeout_o),
        .timeout_clr_i (timeout_clr_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s value=0x%0h", tag, obs);
        end
    endtask

    // Move to the next falling edge, where the bench drives inputs.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = 2'b11; m0_we_i = 1'b0;
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = 2'b11; m1_we_i = 1'b0;
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        s_dat_i = '0; s_ack_i = 1'b0; timeout_clr_i = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        next_cycle();
        idle_inputs();
        resetn = 1'b1;
        next_cycle();
        resetn = 1'b0;
        settle();
        check({tag, "_grant"},   32'(grant_o),   32'h0);
        check({tag, "_s_cyc"},   32'(s_cyc_o),   32'h0);
        check({tag, "_timeout"}, 32'(timeout_o), 32'h0);
        check({tag, "_acks"},    32'({m1_ack_o, m0_ack_o}), 32'h0);
        check({tag, "_dat0"},    32'(m0_dat_o),  32'h0);
    endtask

    int rem [2];
    int ack_cnt [2];

    initial begin
        idle_inputs();
        resetn = 1'b1;
        do_reset("rst");

        // ---- 1: single master read, slave acks two clocks after stb -------
        next_cycle();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 15'h2004;
        settle();
        check("t1_grant_req_cycle", 32'(grant_o), 32'h0);
        next_cycle();
        settle();
        check("t1_grant", 32'(grant_o), 32'h1);
        check("t1_s_adr", 32'(s_adr_o), 32'h2004);
        check("t1_stall_ack", 32'(m0_ack_o), 32'h0);
        next_cycle();
        settle();
        check("t1_stall_ack2", 32'(m0_ack_o), 32'h0);
        next_cycle();
        s_ack_i = 1'b1; s_dat_i = 16'h1234;
        settle();
        check("t1_m0_ack", 32'(m0_ack_o), 32'h1);
        check("t1_m0_dat", 32'(m0_dat_o), 32'h1234);
        check("t1_m1_ack", 32'(m1_ack_o), 32'h0);
        check("t1_m1_dat", 32'(m1_dat_o), 32'h0);
        next_cycle();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        settle();
        check("t1_release", 32'(s_cyc_o), 32'h0);

        // ---- 2: contention fairness, 4 single-beat transfers each ---------
        do_reset("rst2");
        rem[0] = 4; rem[1] = 4; ack_cnt[0] = 0; ack_cnt[1] = 0;
        m0_adr_i = 15'h0010; m1_adr_i = 15'h0020;
        for (int k = 0; k < 8; k++) begin
            int e;
            e = k % 2;
            next_cycle();
            m0_cyc_i = (rem[0] > 0); m0_stb_i = (rem[0] > 0);
            m1_cyc_i = (rem[1] > 0); m1_stb_i = (rem[1] > 0);
            s_ack_i = 1'b0;
            settle();
            check($sformatf("t2_idle_%0d", k), 32'(grant_o), 32'h0);
            next_cycle();
            s_ack_i = 1'b1; s_dat_i = 16'(k);
            settle();
            check($sformatf("t2_grant_%0d", k), 32'(grant_o), (e == 0) ? 32'h1 : 32'h2);
            ack_cnt[0] += int'(m0_ack_o);
            ack_cnt[1] += int'(m1_ack_o);
            rem[e]--;
            next_cycle();
            s_ack_i = 1'b0;
            if (e == 0) begin m0_cyc_i = 1'b0; m0_stb_i = 1'b0; end
            else        begin m1_cyc_i = 1'b0; m1_stb_i = 1'b0; end
            settle();
            check($sformatf("t2_drop_%0d", k), 32'(s_cyc_o), 32'h0);
        end
        check("t2_m0_acks", 32'(ack_cnt[0]), 32'd4);
        check("t2_m1_acks", 32'(ack_cnt[1]), 32'd4);

        // ---- 3: grant held across three m1 beats while m0 waits ------------
        next_cycle();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 15'h3000;
        m0_adr_i = 15'h0555;
        next_cycle();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        for (int b = 0; b < 3; b++) begin
            if (b > 0) next_cycle();
            m1_adr_i = 15'(15'h3000 + b);
            s_ack_i = 1'b1; s_dat_i = 16'(16'hA000 + b);
            settle();
            check($sformatf("t3_grant_b%0d", b), 32'(grant_o), 32'h2);
            check($sformatf("t3_adr_b%0d", b), 32'(s_adr_o), 32'(15'h3000 + b));
            check($sformatf("t3_m0_ack_b%0d", b), 32'(m0_ack_o), 32'h0);
            check($sformatf("t3_m1_dat_b%0d", b), 32'(m1_dat_o), 32'(16'hA000 + b));
        end
        next_cycle();
        s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        settle();
        check("t3_m1_drop_grant", 32'(grant_o), 32'h2);
        next_cycle();
        settle();
        check("t3_turnaround", 32'(grant_o), 32'h0);
        next_cycle();
        s_ack_i = 1'b1; s_dat_i = 16'h0F0F;
        settle();
        check("t3_m0_grant", 32'(grant_o), 32'h1);
        check("t3_m0_adr", 32'(s_adr_o), 32'h0555);
        check("t3_m0_ack", 32'(m0_ack_o), 32'h1);
        next_cycle();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;

        // ---- 4: slave never acks -> abort after 8 stb cycles ---------------
        next_cycle();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 15'h1111;
        for (int i = 1; i <= 8; i++) begin
            next_cycle();
            settle();
            if (i == 1 || i == 8)
                check($sformatf("t4_stall_cyc_%0d", i), 32'(s_cyc_o), 32'h1);
        end
        next_cycle();
        settle();
        check("t4_abort_s_cyc", 32'(s_cyc_o), 32'h0);
        check("t4_abort_s_stb", 32'(s_stb_o), 32'h0);
        check("t4_abort_ack", 32'(m0_ack_o), 32'h1);
        check("t4_abort_dat", 32'(m0_dat_o), 32'hDEAD);
        check("t4_abort_m1_ack", 32'(m1_ack_o), 32'h0);
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        next_cycle();
        settle();
        check("t4_flag_set", 32'(timeout_o), 32'h1);
        check("t4_ack_single", 32'(m0_ack_o), 32'h0);
        repeat (3) next_cycle();
        settle();
        check("t4_flag_sticky", 32'(timeout_o), 32'h1);
        next_cycle();
        timeout_clr_i = 1'b1;
        settle();
        check("t4_flag_before_clr_edge", 32'(timeout_o), 32'h1);
        next_cycle();
        timeout_clr_i = 1'b0;
        settle();
        check("t4_flag_cleared", 32'(timeout_o), 32'h0);

        // ---- 5a: ack on the 8th stall cycle is a normal completion --------
        next_cycle();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 15'h0042;
        repeat (7) next_cycle();
        next_cycle();
        s_ack_i = 1'b1; s_dat_i = 16'hBEEF;
        settle();
        check("t5_edge_ack", 32'(m0_ack_o), 32'h1);
        check("t5_edge_dat", 32'(m0_dat_o), 32'hBEEF);
        next_cycle();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        settle();
        check("t5_no_abort_ack", 32'(m0_ack_o), 32'h0);
        next_cycle();
        settle();
        check("t5_no_flag", 32'(timeout_o), 32'h0);

        // ---- 5b: timeout coincident with clear; master keeps cyc ----------
        next_cycle();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 15'h0043;
        repeat (8) next_cycle();
        next_cycle();
        m0_stb_i = 1'b0; timeout_clr_i = 1'b1;
        settle();
        check("t5_abort_ack", 32'(m0_ack_o), 32'h1);
        next_cycle();
        timeout_clr_i = 1'b0;
        settle();
        check("t5_set_wins", 32'(timeout_o), 32'h1);
        check("t5_back_to_own", 32'(grant_o), 32'h1);
        check("t5_back_s_cyc", 32'(s_cyc_o), 32'h1);
        next_cycle();
        m0_cyc_i = 1'b0;

        // ---- 6: reset while m1 is stalled ----------------------------------
        next_cycle();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 15'h0777;
        next_cycle();
        settle();
        check("t6_m1_grant", 32'(grant_o), 32'h2);
        check("t6_m1_adr", 32'(s_adr_o), 32'h0777);
        next_cycle();
        resetn = 1'b1; s_ack_i = 1'b1; s_dat_i = 16'h5555;
        settle();
        check("t6_ack_blocked", 32'(m1_ack_o), 32'h0);
        next_cycle();
        resetn = 1'b0; s_ack_i = 1'b0;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 15'h0100;
        settle();
        check("t6_grant_released", 32'(grant_o), 32'h0);
        check("t6_s_cyc_released", 32'(s_cyc_o), 32'h0);
        check("t6_no_m1_ack", 32'(m1_ack_o), 32'h0);
        check("t6_flag_reset", 32'(timeout_o), 32'h0);
        next_cycle();
        settle();
        check("t6_m0_first", 32'(grant_o), 32'h1);
        check("t6_m0_adr", 32'(s_adr_o), 32'h0100);
        next_cycle();
        idle_inputs();
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_master_arbiter.md
Name: wb_master_arbiter

Overview:
- Two-master, one-port Wishbone arbiter. It places m0 (RPi SPI master) and m1 (a second on-chip master, e.g. a DMA/capture engine) in front of the single master port of the bus interconnect.
- Arbitration is round-robin and per-cycle, with a grant held for the whole cyc.
- A watchdog terminates any transfer whose slave never acks, so a hung slave cannot lock the bus.

Parameters:
- ADDR_WIDTH, 15, address width of all ports.
- DATA_WIDTH, 16, data width of all ports.
- TIMEOUT_CYCLES, 255, number of stb-without-ack cycles before forced termination. Legal range 2..65535.
- TIMEOUT_DATA, 16'hDEAD, read data returned to the master on a timed-out access.

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous reset, active-high (1 = reset).
- m0_adr_i  in  ADDR_WIDTH  master 0 address.
- m0_dat_i  in  DATA_WIDTH  master 0 write data.
- m0_dat_o  out  DATA_WIDTH  master 0 read data.
- m0_sel_i  in  2  master 0 byte select.
- m0_we_i  in  1  master 0 write enable.
- m0_cyc_i  in  1  master 0 cycle.
- m0_stb_i  in  1  master 0 strobe.
- m0_ack_o  out  1  master 0 acknowledge.
- m1_* (adr_i, dat_i, dat_o, sel_i, we_i, cyc_i, stb_i, ack_o): identical set for master 1.
- s_adr_o  out  ADDR_WIDTH  to interconnect.
- s_dat_o  out  DATA_WIDTH  write data to interconnect.
- s_dat_i  in  DATA_WIDTH  read data from interconnect.
- s_sel_o  out  2  byte select.
- s_we_o  out  1  write enable.
- s_cyc_o  out  1  cycle.
- s_stb_o  out  1  strobe.
- s_ack_i  in  1  acknowledge from interconnect.
- grant_o  out  2  one-hot current owner ({m1,m0}); 2'b00 when idle.
- timeout_o  out  1  sticky flag: at least one access timed out.
- timeout_clr_i  in  1  clears timeout_o.

Behaviour:
- State machine: IDLE, OWN0, OWN1, ABORT. Registered state; last_owner register (1 bit).

Reset:
- state=IDLE, last_owner=1 (so m0 wins the first tie), timer=0, timeout_o=0.
- All s_* outputs 0, m*_ack_o=0, m*_dat_o=0, grant_o=0.
- Reset asserted mid-transfer aborts it immediately: no ack is issued and the bus is released on the following edge.

IDLE:
- Only m0_cyc_i=1 → OWN0. Only m1_cyc_i=1 → OWN1.
- Both asserted → the master not equal to last_owner.
- Neither asserted → stay.
- Grant takes effect on the next edge. Minimum request-to-s_cyc_o latency is 1 clk.

OWNx:
- s_adr/dat/sel/we/cyc/stb_o are driven combinationally from master x.
- m_x_ack_o = s_ack_i and m_x_dat_o = s_dat_i, both combinational (zero added latency on the data phase).
- The non-owner sees ack=0 and dat_o=0.
- Exit to IDLE when m_x_cyc_i=0; last_owner<=x on exit.
- The grant is not revoked while cyc is held, even across multiple stb/ack beats.
- One IDLE turnaround cycle always separates two grants.

Timer:
- In OWNx, increments each cycle with s_stb_o=1 and s_ack_i=0.
- Clears on s_ack_i=1 or when stb=0.
- When timer reaches TIMEOUT_CYCLES-1 with no ack → ABORT.

ABORT (exactly 1 cycle):
- s_cyc_o=s_stb_o=0.
- m_x_ack_o=1 and m_x_dat_o=TIMEOUT_DATA, registered.
- timeout_o<=1; timer<=0.
- Then returns to OWNx if m_x_cyc_i is still 1, else IDLE.
- Writes are silently dropped.

Timeout flag:
- A simultaneous timeout event and timeout_clr_i leaves timeout_o=1 (set wins).
- timeout_clr_i alone clears it on the next edge.
- An ack arriving in the same cycle the timer reaches its limit is honoured as a normal ack; no abort occurs.

Width rules: timer is clog2(TIMEOUT_CYCLES+1) bits and never wraps.

Test Plan:
1. Single master: m0 read 0x2004 with slave acking 2 clks after stb, s_dat_i=0x1234 → grant_o=01 one clk after cyc; m0_ack_o pulses once with m0_dat_o=0x1234; m1_ack_o stays 0.
2. Contention fairness: m0 and m1 both assert cyc in the same cycle, each doing 4 back-to-back single-beat transactions (cyc dropped after each ack) → grant order 01,10,01,10,...; exactly one idle cycle between grants; each gets 4 acks.
3. Grant hold: m1 owns and holds cyc for 3 beats (0x3000,0x3001,0x3002) while m0 requests → m0 is granted only after m1 drops cyc; no beats are interleaved.
4. Timeout: TIMEOUT_CYCLES=8; m0 reads an address whose slave never acks → after 8 stb cycles s_cyc_o drops; m0_ack_o=1 with m0_dat_o=0xDEAD for 1 clk; timeout_o=1 and stays 1 until timeout_clr_i is pulsed.
5. Boundary: ack arrives on the 8th stall cycle (TIMEOUT_CYCLES=8) → normal ack with s_dat_i data; timeout_o stays 0. Also timeout and timeout_clr_i in the same cycle → timeout_o=1.
6. Reset mid-operation: assert resetn for 1 clk while OWN1 is stalled → next cycle grant_o=00, s_cyc_o=0, no ack to m1; after reset, a simultaneous request grants m0 first.
